// File: rtl/axi_ram_slave.sv
// axi_ram_slave
//   AXI3-style 32-bit memory responder. Independent read and write engines.
//   Each engine accepts one burst at a time (FIXED/INCR, WRAP handled as INCR,
//   up to 256 beats) against a word-addressed RAM of 2^ADDR_WIDTH words.
//   Reads return their first beat READ_LAT cycles after the AR handshake.
//
// Ports
//   clk, resetn                      clock (rising edge), async active-low reset
//   ar* / arvalid / arready          read address channel
//   rid/rdata/rresp/rlast/rvalid     read data channel, rready from master
//   aw* / awvalid / awready          write address channel
//   wid/wdata/wstrb/wlast/wvalid     write data channel, wready to master
//   bid/bresp/bvalid                 write response channel, bready from master
//   ar/aw lock, cache, prot          accepted, no effect
module axi_ram_slave #(
  parameter int    ADDR_WIDTH = 16,
  parameter int    READ_LAT   = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int   DEPTH    = 1 << ADDR_WIDTH;
  localparam logic HAS_INIT = (INIT_FILE != "");

  logic [31:0] mem [DEPTH];

  // FIXED keeps the address; everything else steps by the transfer size.
  function automatic logic [31:0] addr_step(input logic [1:0] burst, input logic [2:0] size);
    if (burst == 2'b00) return 32'd0;
    return 32'd1 << size;
  endfunction

  function automatic logic [1:0] size_resp(input logic [2:0] size);
    return (size > 3'd2) ? 2'b10 : 2'b00;
  endfunction

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [3:0]  r_id, w_id;
  logic [31:0] r_addr, w_addr;
  logic [7:0]  r_len, r_cnt, w_len, w_cnt;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_burst, w_burst;
  logic [3:0]  r_lat;
  logic        w_err;
  logic [31:0] r_hold;
  logic        r_hold_vld;

  logic [ADDR_WIDTH-1:0] r_idx, w_idx;
  logic                  w_at_len;

  assign r_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_idx    = w_addr[ADDR_WIDTH+1:2];
  assign w_at_len = (w_cnt == w_len);

  // ---------------- read engine ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_WAIT;
      end
      R_WAIT: if (r_lat == 4'd0) r_next = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && (r_cnt == r_len)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_lat      <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_id       <= arid;
          r_addr     <= araddr;
          r_len      <= arlen;
          r_size     <= arsize;
          r_burst    <= arburst;
          r_cnt      <= '0;
          r_lat      <= 4'(READ_LAT - 1);
          r_hold_vld <= 1'b0;
        end
        R_WAIT: if (r_lat != 4'd0) r_lat <= r_lat - 4'd1;
        R_DATA: begin
          if (rready) begin
            r_addr     <= r_addr + addr_step(r_burst, r_size);
            r_cnt      <= r_cnt + 8'd1;
            r_hold_vld <= 1'b0;
          end else begin
            r_hold_vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A stalled beat freezes its data so a concurrent write to the same word
  // cannot change rdata while the master is not ready.
  always_ff @(posedge clk) begin
    if (r_state == R_DATA && !rready && !r_hold_vld) r_hold <= mem[r_idx];
  end

  assign rdata = r_hold_vld ? r_hold : mem[r_idx];
  assign rid   = r_id;
  assign rlast = (r_state == R_DATA) && (r_cnt == r_len);
  assign rresp = (r_state == R_DATA) ? size_resp(r_size) : 2'b00;

  // ---------------- write engine ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (wlast || w_at_len)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_addr + addr_step(w_burst, w_size);
          w_cnt  <= w_cnt + 8'd1;
          // wlast out of step with the beat count, early or late
          if (wlast != w_at_len) w_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_state == W_DATA && wvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bid   = w_id;
  assign bresp = (w_state == W_RESP && (w_err || size_resp(w_size) != 2'b00)) ? 2'b10 : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot, HAS_INIT};

endmodule

// File: tb/tb_axi_ram_slave.sv
module tb_axi_ram_slave;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdat [0:15];
  logic [3:0]  wstb [0:15];
  logic [31:0] rd_data [0:15];
  logic        rd_last [0:15];
  logic [3:0]  rd_id [0:15];
  logic [1:0]  rd_resp [0:15];

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_WIDTH(16), .READ_LAT(2), .INIT_FILE("")) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Drives one write burst of nbeats beats from wdat/wstb; wlast on beat last_idx.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                           input int last_idx, output bit ok, output logic [1:0] resp,
                           output logic [3:0] rbid);
    int n;
    ok = 1'b1; resp = 2'b11; rbid = 4'h0;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin ok = 1'b0; awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == last_idx); wid = id; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin ok = 1'b0; wvalid = 1'b0; wlast = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) ok = 1'b0;
    else begin resp = bresp; rbid = bid; end
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Issues one read burst, records beats into rd_*; optionally stalls rready
  // for stall_cycles when beat stall_beat is first offered.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int nexp,
                          input int stall_beat, input int stall_cycles, output bit ok,
                          output int lat, output int got, output int unstable);
    int cyc;
    int stall_left;
    logic [31:0] sd;
    logic sl;
    logic [3:0] si;
    ok = 1'b1; lat = 0; got = 0; unstable = 0; stall_left = stall_cycles;
    sd = '0; sl = 1'b0; si = '0;
    @(posedge clk); #1;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!arready) begin ok = 1'b0; arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    while (!rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rvalid) begin ok = 1'b0; rready = 1'b0; return; end
    cyc = 0;
    while (got < nexp && cyc < 400) begin
      if (rvalid && got == stall_beat && stall_left > 0) begin
        if (stall_left == stall_cycles) begin sd = rdata; sl = rlast; si = rid; end
        else if (rdata !== sd || rlast !== sl || rid !== si) unstable++;
        rready = 1'b0;
        stall_left--;
      end else begin
        rready = 1'b1;
        if (rvalid) begin
          rd_data[got] = rdata; rd_last[got] = rlast; rd_id[got] = rid; rd_resp[got] = rresp;
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (got < nexp) ok = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got %b want 1", arready); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got %b want 1", awready); end
    checks++; if ({rvalid, wready, bvalid, rlast} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b want 0000", {rvalid, wready, bvalid, rlast}); end
    checks++; if ({rresp, bresp} !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b want 0000", {rresp, bresp}); end
    checks++; if ({rid, bid} !== 8'h00) begin errors++; $display("FAIL reset_ids got %h want 00", {rid, bid}); end
  endtask

  task automatic test_single_read;
    bit ok; logic [1:0] resp; logic [3:0] rb; int lat, got, uns;
    wdat[0] = 32'h12345678; wstb[0] = 4'hF;
    axi_write(32'h40, 8'd0, 3'd2, 2'b01, 4'h1, 1, 0, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b00 || rb !== 4'h1) begin errors++; $display("FAIL single_wr ok=%0d bresp=%b bid=%h want 1/00/1", ok, resp, rb); end
    axi_read(32'h40, 8'd0, 3'd2, 2'b01, 4'h3, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || got != 1) begin errors++; $display("FAIL single_rd_beats got %0d want 1", got); end
    checks++; if (lat != 2) begin errors++; $display("FAIL single_rd_latency got %0d want 2", lat); end
    checks++; if (rd_data[0] !== 32'h12345678) begin errors++; $display("FAIL single_rd_data got %h want 12345678", rd_data[0]); end
    checks++; if ({rd_last[0], rd_id[0], rd_resp[0]} !== {1'b1, 4'h3, 2'b00}) begin errors++; $display("FAIL single_rd_ctl got last=%b id=%h resp=%b want 1/3/00", rd_last[0], rd_id[0], rd_resp[0]); end
    axi_read(32'h40 | (32'h1 << 18), 8'd0, 3'd2, 2'b01, 4'h3, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'h12345678) begin errors++; $display("FAIL alias_rd got %h want 12345678", rd_data[0]); end
  endtask

  task automatic test_incr_burst;
    bit ok; logic [1:0] resp; logic [3:0] rb; int lat, got, uns;
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; end
    axi_write(32'h100, 8'd3, 3'd2, 2'b01, 4'h5, 4, 3, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b00 || rb !== 4'h5) begin errors++; $display("FAIL incr_wr ok=%0d bresp=%b bid=%h want 1/00/5", ok, resp, rb); end
    axi_read(32'h100, 8'd3, 3'd2, 2'b01, 4'h9, 4, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || got != 4) begin errors++; $display("FAIL incr_rd_beats got %0d want 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3) || rd_id[i] !== 4'h9) begin
        errors++; $display("FAIL incr_rd_beat%0d got data=%h last=%b id=%h want %h/%b/9", i, rd_data[i], rd_last[i], rd_id[i], 32'hA0 + i, (i == 3));
      end
    end
    axi_read(32'h10C, 8'd0, 3'd2, 2'b01, 4'h0, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'hA3) begin errors++; $display("FAIL incr_rd_10c got %h want 000000a3", rd_data[0]); end
  endtask

  task automatic test_partial_strobe;
    bit ok; logic [1:0] resp; logic [3:0] rb; int lat, got, uns;
    wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
    axi_write(32'h200, 8'd0, 3'd2, 2'b01, 4'h2, 1, 0, ok, resp, rb);
    wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
    axi_write(32'h200, 8'd0, 3'd2, 2'b01, 4'h2, 1, 0, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL strobe_wr ok=%0d bresp=%b want 1/00", ok, resp); end
    axi_read(32'h200, 8'd0, 3'd2, 2'b01, 4'h2, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'hFF22FF44) begin errors++; $display("FAIL strobe_rd got %h want ff22ff44", rd_data[0]); end
  endtask

  task automatic test_wlast_errors;
    bit ok; logic [1:0] resp; logic [3:0] rb; int lat, got, uns;
    wdat[0] = 32'h77; wdat[1] = 32'h78; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(32'h300, 8'd3, 3'd2, 2'b01, 4'h6, 2, 1, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b10 || rb !== 4'h6) begin errors++; $display("FAIL early_wlast ok=%0d bresp=%b bid=%h want 1/10/6", ok, resp, rb); end
    axi_read(32'h304, 8'd0, 3'd2, 2'b01, 4'h0, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'h78) begin errors++; $display("FAIL early_wlast_data got %h want 00000078", rd_data[0]); end
    wdat[0] = 32'h55;
    axi_write(32'h300, 8'd0, 3'd2, 2'b01, 4'h7, 1, 0, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b00 || rb !== 4'h7) begin errors++; $display("FAIL after_early ok=%0d bresp=%b bid=%h want 1/00/7", ok, resp, rb); end
    wdat[0] = 32'h1; wdat[1] = 32'h2;
    axi_write(32'h310, 8'd1, 3'd2, 2'b01, 4'h8, 2, -1, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b10) begin errors++; $display("FAIL late_wlast ok=%0d bresp=%b want 1/10", ok, resp); end
  endtask

  task automatic test_fixed_size;
    bit ok; logic [1:0] resp; logic [3:0] rb; int lat, got, uns;
    wdat[0] = 32'hDEAD0404; wstb[0] = 4'hF;
    axi_write(32'h404, 8'd0, 3'd2, 2'b01, 4'h1, 1, 0, ok, resp, rb);
    for (int i = 0; i < 3; i++) begin wdat[i] = i + 1; wstb[i] = 4'hF; end
    axi_write(32'h400, 8'd2, 3'd2, 2'b00, 4'h1, 3, 2, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL fixed_wr ok=%0d bresp=%b want 1/00", ok, resp); end
    axi_read(32'h400, 8'd0, 3'd2, 2'b01, 4'h0, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'h3) begin errors++; $display("FAIL fixed_rd got %h want 00000003", rd_data[0]); end
    axi_read(32'h404, 8'd0, 3'd2, 2'b01, 4'h0, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'hDEAD0404) begin errors++; $display("FAIL fixed_neighbour got %h want dead0404", rd_data[0]); end
    wdat[0] = 32'hCAFE;
    axi_write(32'h408, 8'd0, 3'd3, 2'b01, 4'h1, 1, 0, ok, resp, rb);
    checks++; if (!ok || resp !== 2'b10) begin errors++; $display("FAIL size_wr ok=%0d bresp=%b want 1/10", ok, resp); end
    axi_read(32'h408, 8'd0, 3'd3, 2'b01, 4'h0, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'hCAFE || rd_resp[0] !== 2'b10) begin errors++; $display("FAIL size_rd got %h/%b want 0000cafe/10", rd_data[0], rd_resp[0]); end
  endtask

  task automatic test_rready_stall;
    bit ok; int lat, got, uns;
    axi_read(32'h100, 8'd3, 3'd2, 2'b01, 4'hC, 4, 1, 5, ok, lat, got, uns);
    checks++; if (!ok || got != 4) begin errors++; $display("FAIL stall_beats got %0d want 4", got); end
    checks++; if (uns != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", uns); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3) || rd_id[i] !== 4'hC) begin
        errors++; $display("FAIL stall_beat%0d got %h/%b/%h want %h/%b/c", i, rd_data[i], rd_last[i], rd_id[i], 32'hA0 + i, (i == 3));
      end
    end
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL stall_after rvalid=%b arready=%b want 0/1", rvalid, arready); end
  endtask

  task automatic test_reset_mid_burst;
    bit ok; int lat, got, uns, n;
    @(posedge clk); #1;
    araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 4'h7; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hA2) begin errors++; $display("FAIL midrst_beat2 got rvalid=%b data=%h want 1/000000a2", rvalid, rdata); end
    resetn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin errors++; $display("FAIL midrst_async got rvalid=%b rlast=%b want 0/0", rvalid, rlast); end
    rready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL midrst_release arready=%b rvalid=%b want 1/0", arready, rvalid); end
    axi_read(32'h40, 8'd0, 3'd2, 2'b01, 4'h4, 1, -1, 0, ok, lat, got, uns);
    checks++; if (!ok || rd_data[0] !== 32'h12345678 || rd_id[0] !== 4'h4) begin errors++; $display("FAIL midrst_next got %h/%h want 12345678/4", rd_data[0], rd_id[0]); end
  endtask

  initial begin
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    test_single_read();
    test_incr_burst();
    test_partial_strobe();
    test_wlast_errors();
    test_fixed_size();
    test_rready_stall();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
AXI3-style 32-bit memory responder: the target end of the CPU's axi_bridge master interface.
Serves instruction and data traffic from the core in simulation and FPGA bring-up; sits between the CPU top-level AXI ports and a word-addressed RAM array.
Read and write channels are independent; each supports one outstanding burst (FIXED/INCR, up to 256 beats) with a programmable read latency.

Parameters:
ADDR_WIDTH, 16, word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
READ_LAT, 2, cycles from AR handshake to first rvalid (1..15).
INIT_FILE, "", optional $readmemh image; empty means RAM starts at zero.

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel
arvalid  in  1 ; arready  out  1
rid  out  4 ; rdata  out  32 ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address channel
awvalid  in  1 ; awready  out  1
wid  in  4 ; wdata  in  32 ; wstrb  in  4 ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
bid  out  4 ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
(arlock/arcache/arprot and aw equivalents accepted and ignored.)

Behaviour:
- Reset (resetn=0, async): read FSM=R_IDLE, write FSM=W_IDLE; arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rresp=bresp=0, rid=bid=0. In-flight bursts are discarded, with no response. RAM contents are not cleared.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored (aliasing). Low 2 bits do not shift data lanes.
- Beat address step = 1<<size when burst=INCR (01), 0 when FIXED (00). WRAP (10) is treated as INCR. Size >2 gives SLVERR on every beat/response while the transfer is still performed.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst, clear beat counter, load latency counter with READ_LAT-1, then go to R_WAIT.
  - R_WAIT: arready=0. Decrement counter; at 0 go to R_DATA. First rvalid is asserted exactly READ_LAT cycles after the AR handshake edge.
  - R_DATA: rvalid=1, rdata=mem[word index], rid=latched id, rlast=(count==len). rdata/rlast/rid are held stable while rvalid&~rready.
  - On rvalid&rready: advance address and count. If it is the last beat, return to R_IDLE; arready rises the next cycle.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst and clear count/err, then go to W_DATA.
  - W_DATA: wready=1. On wvalid&wready, write each byte lane i where wstrb[i]=1, then advance address/count.
  - Burst end = wlast OR count==len. At burst end, go to W_RESP. Set err if wlast≠(count==len); this covers both early and late wlast. wid is not checked.
  - W_RESP: bvalid=1, bid=latched awid, bresp=err?2'b10:2'b00. On bready, return to W_IDLE.
- W beats arriving before the AW handshake are not accepted (wready=0 in W_IDLE).
- The read and write paths run concurrently. A write beat committed on edge N is visible to any read beat presented from cycle N+1. A same-cycle same-address write/read returns the old data.
- Backpressure: arbitrary rready/bready deassertion never drops or duplicates a beat.

Test Plan:
1. mem[0x40>>2]=0x12345678. Single read araddr=0x40, arlen=0, READ_LAT=2 → rvalid 2 cycles after AR, rdata=0x12345678, rlast=1, rid=arid=4'h3, rresp=0.
2. INCR write awaddr=0x100, awlen=3, size=2, data 0xA0..0xA3, wstrb=4'hF; then read-back arlen=3 → words 0x100..0x10C return 0xA0..0xA3, rlast only on beat 3, bresp=0.
3. Partial strobe: mem[0x200]=0xFFFFFFFF, write 0x11223344 with wstrb=4'b0101 → reads 0xFF22FF44.
4. Early wlast on beat 1 of awlen=3 → write FSM stops, bvalid with bresp=2'b10, later AW accepted normally.
5. rready held low 5 cycles mid-burst → rdata/rlast/rid stable, no beat lost, 4 beats total.
6. resetn pulsed low during R_DATA beat 2 → rvalid=0 immediately, arready=1 after release, next read returns correct data.
